// File: rtl/store_drain_pkg.sv
// rtl/store_drain_pkg.sv - shared store-path types: size enum, drain FSM state, FIFO entry
package store_drain_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } store_size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    store_size_t size;
  } store_entry_t;

  localparam int ENTRY_W = $bits(store_entry_t);

  // True when the access fits inside one aligned word at the given byte offset.
  function automatic logic size_aligned(store_size_t size, logic [1:0] off);
    case (size)
      SZ_BYTE: size_aligned = 1'b1;
      SZ_HALF: size_aligned = ~off[0];
      SZ_WORD: size_aligned = (off == 2'b00);
      default: size_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_drain_if.sv
// rtl/store_drain_if.sv - store-in and memory-write-out signal bundle for store_drain
interface store_drain_if;
  logic [31:0] store_addr;
  logic [31:0] store_val;
  logic [1:0]  store_size;
  logic        store_valid;
  logic        storefifo_full;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req;
  logic        mem_ack;
  logic        store_empty;
  logic        store_err;

  // store_drain side
  modport slave (
    input  store_addr, store_val, store_size, store_valid, mem_ack,
    output storefifo_full, mem_addr, mem_wdata, mem_wstrb, mem_req,
           store_empty, store_err
  );

  // producer / memory side
  modport master (
    output store_addr, store_val, store_size, store_valid, mem_ack,
    input  storefifo_full, mem_addr, mem_wdata, mem_wstrb, mem_req,
           store_empty, store_err
  );
endinterface

// File: rtl/store_drain_sync_fifo.sv
// rtl/store_drain_sync_fifo.sv - generic synchronous FIFO with registered count and show-ahead head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come only from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage needs no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap at DEPTH (power of two); count moves only on unbalanced push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_drain.sv
// rtl/store_drain.sv - buffers committed stores and drains them as byte-strobed memory writes
module store_drain
  import store_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  store_drain_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  store_entry_t       in_entry;
  store_entry_t       head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CW-1:0]      count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  drain_state_t       state;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [3:0]         mem_wstrb_q;
  logic               store_err_q;

  logic               fmt_legal;
  logic [3:0]         fmt_wstrb;
  logic [31:0]        fmt_wdata;
  logic [1:0]         off;

  assign in_entry = '{addr: bus.store_addr,
                      val:  bus.store_val,
                      size: store_size_t'(bus.store_size)};
  assign push     = bus.store_valid && !fifo_full;
  assign head     = store_entry_t'(head_bits);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head_bits),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Place the head entry onto byte lanes; unaligned or bad-size entries are flagged illegal.
  always_comb begin
    off       = head.addr[1:0];
    fmt_legal = size_aligned(head.size, off);
    fmt_wstrb = 4'b0000;
    fmt_wdata = 32'h0;
    case (head.size)
      SZ_BYTE: begin
        fmt_wstrb = 4'b0001 << off;
        fmt_wdata = {4{head.val[7:0]}};
      end
      SZ_HALF: begin
        fmt_wstrb = 4'b0011 << off;
        fmt_wdata = {2{head.val[15:0]}};
      end
      SZ_WORD: begin
        fmt_wstrb = 4'b1111;
        fmt_wdata = head.val;
      end
      default: begin
        fmt_wstrb = 4'b0000;
        fmt_wdata = 32'h0;
      end
    endcase
  end

  // Idle always consumes the head (to issue or to drop it); an acked request only chains into a legal head.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || (bus.mem_ack && fmt_legal));

  // Drain FSM: holds the output stage stable until ack, chaining back-to-back legal entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      store_err_q <= 1'b0;
    end else begin
      store_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (fmt_legal) begin
              state       <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {head.addr[31:2], 2'b00};
              mem_wdata_q <= fmt_wdata;
              mem_wstrb_q <= fmt_wstrb;
            end else begin
              store_err_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            if (!fifo_empty && fmt_legal) begin
              mem_addr_q  <= {head.addr[31:2], 2'b00};
              mem_wdata_q <= fmt_wdata;
              mem_wstrb_q <= fmt_wstrb;
            end else begin
              state     <= ST_IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.storefifo_full = fifo_full;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.store_err      = store_err_q;
  assign bus.store_empty    = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_store_drain.sv
// tb/tb_store_drain.sv - directed self-checking bench for store_drain
module tb_store_drain;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  store_drain_if sif();

  store_drain #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    sif.store_valid = 1'b1;
    sif.store_addr  = a;
    sif.store_val   = v;
    sif.store_size  = s;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    offer(a, v, s);
    step();
    sif.store_valid = 1'b0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    sif.store_valid   = 1'b0;
    sif.store_addr    = 32'h0;
    sif.store_val     = 32'h0;
    sif.store_size    = 2'd0;
    sif.mem_ack       = 1'b0;

    // reset state
    #1;
    chk("rst_req",   32'(sif.mem_req), 32'd0);
    chk("rst_addr",  sif.mem_addr, 32'h0);
    chk("rst_wdata", sif.mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(sif.mem_wstrb), 32'h0);
    chk("rst_err",   32'(sif.store_err), 32'd0);
    chk("rst_full",  32'(sif.storefifo_full), 32'd0);
    chk("rst_empty", 32'(sif.store_empty), 32'd1);
    #20;
    reset = 1'b0;

    // single word store, ack tied high
    sif.mem_ack = 1'b1;
    push_one(32'h1000, 32'hDEADBEEF, 2'd2);
    chk("sw_req_e0",   32'(sif.mem_req), 32'd0);
    chk("sw_empty_e0", 32'(sif.store_empty), 32'd0);
    step();
    chk("sw_req",   32'(sif.mem_req), 32'd1);
    chk("sw_addr",  sif.mem_addr, 32'h1000);
    chk("sw_wstrb", 32'(sif.mem_wstrb), 32'hF);
    chk("sw_wdata", sif.mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_req_done", 32'(sif.mem_req), 32'd0);
    chk("sw_empty",    32'(sif.store_empty), 32'd1);

    // byte then half, back to back
    push_one(32'h2003, 32'h000000AB, 2'd0);
    push_one(32'h2002, 32'h00001234, 2'd1);
    chk("sb_addr",  sif.mem_addr, 32'h2000);
    chk("sb_wstrb", 32'(sif.mem_wstrb), 32'h8);
    chk("sb_wdata", sif.mem_wdata, 32'hABABABAB);
    step();
    chk("sh_req",   32'(sif.mem_req), 32'd1);
    chk("sh_addr",  sif.mem_addr, 32'h2000);
    chk("sh_wstrb", 32'(sif.mem_wstrb), 32'hC);
    chk("sh_wdata", sif.mem_wdata, 32'h12341234);
    step();
    chk("sh_empty", 32'(sif.store_empty), 32'd1);

    // backpressure: five stores fill output stage plus FIFO
    sif.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_notfull", 32'(sif.storefifo_full), 32'd0);
      push_one(32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 2'd2);
    end
    chk("bp_full",  32'(sif.storefifo_full), 32'd1);
    chk("bp_req",   32'(sif.mem_req), 32'd1);
    chk("bp_addr0", sif.mem_addr, 32'h4000);
    offer(32'h4014, 32'h105, 2'd2);
    step();
    step();
    chk("bp_hold_full", 32'(sif.storefifo_full), 32'd1);
    chk("bp_hold_addr", sif.mem_addr, 32'h4000);
    chk("bp_hold_cnt",  32'(dut.count), 32'd4);
    sif.store_valid = 1'b0;
    sif.mem_ack     = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("bp_drain_req",   32'(sif.mem_req), 32'd1);
      chk("bp_drain_addr",  sif.mem_addr, 32'h4000 + 32'(4 * i));
      chk("bp_drain_wdata", sif.mem_wdata, 32'h100 + 32'(i));
    end
    step();
    chk("bp_idle",  32'(sif.mem_req), 32'd0);
    chk("bp_empty", 32'(sif.store_empty), 32'd1);

    // misaligned word and illegal size are dropped with a one-cycle error
    push_one(32'h3002, 32'h11111111, 2'd2);
    chk("mis_err0", 32'(sif.store_err), 32'd0);
    step();
    chk("mis_err",  32'(sif.store_err), 32'd1);
    chk("mis_req",  32'(sif.mem_req), 32'd0);
    step();
    chk("mis_err_clr", 32'(sif.store_err), 32'd0);
    chk("mis_empty",   32'(sif.store_empty), 32'd1);
    push_one(32'h3000, 32'h22222222, 2'd3);
    step();
    chk("sz3_err", 32'(sif.store_err), 32'd1);
    chk("sz3_req", 32'(sif.mem_req), 32'd0);
    push_one(32'h3004, 32'h55AA55AA, 2'd2);
    chk("mis_after_err", 32'(sif.store_err), 32'd0);
    step();
    chk("mis_next_req",   32'(sif.mem_req), 32'd1);
    chk("mis_next_addr",  sif.mem_addr, 32'h3004);
    chk("mis_next_wdata", sif.mem_wdata, 32'h55AA55AA);
    step();
    chk("mis_next_idle", 32'(sif.mem_req), 32'd0);

    // steady push/pop at count=2 across pointer wrap
    sif.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++)
      push_one(32'h5000 + 32'(4 * k), 32'hA0000000 + 32'(k), 2'd2);
    chk("ss_cnt0",  32'(dut.count), 32'd2);
    chk("ss_addr0", sif.mem_addr, 32'h5000);
    sif.mem_ack = 1'b1;
    for (int k = 3; k < 20; k++) begin
      push_one(32'h5000 + 32'(4 * k), 32'hA0000000 + 32'(k), 2'd2);
      chk("ss_cnt",   32'(dut.count), 32'd2);
      chk("ss_addr",  sif.mem_addr, 32'h5000 + 32'(4 * (k - 2)));
      chk("ss_wdata", sif.mem_wdata, 32'hA0000000 + 32'(k - 2));
    end
    step();
    chk("ss_tail18", sif.mem_addr, 32'h5000 + 32'(4 * 18));
    step();
    chk("ss_tail19", sif.mem_addr, 32'h5000 + 32'(4 * 19));
    step();
    chk("ss_empty", 32'(sif.store_empty), 32'd1);

    // asynchronous reset during a request with three entries queued
    sif.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++)
      push_one(32'h6000 + 32'(4 * k), 32'h600 + 32'(k), 2'd2);
    chk("rr_req_before", 32'(sif.mem_req), 32'd1);
    chk("rr_cnt_before", 32'(dut.count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_req_async", 32'(sif.mem_req), 32'd0);
    chk("rr_empty",     32'(sif.store_empty), 32'd1);
    chk("rr_addr",      sif.mem_addr, 32'h0);
    #10;
    reset       = 1'b0;
    sif.mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_no_stale", 32'(sif.mem_req), 32'd0);
    end
    chk("rr_empty_after", 32'(sif.store_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
